ram_sdp_arbiter: RTL and testbench

- Shares one byte-enabled simple-dual-port RAM (1 read port, 1 write port, registered addresses, 1-cycle read latency with write forwarding) between NUM_REQ requesters.
- Independent round-robin arbitration for the read port and the write port, so one read and one write can be granted in the same cycle.
- Returns read data to the originating requester with a tagged valid.
- Sits between load/store units and the shared data memory.

---
 rtl/ram_sdp_arbiter.sv | 118 +++++++++++
 tb/tb_ram_sdp_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_arbiter.sv
// ram_sdp_arbiter: round-robin read/write arbiter sharing one simple-dual-port RAM among NUM_REQ requesters.
// Optional RAM_SDP_ARB_STATS_EN adds a saturating stall_count output.
module ram_sdp_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 8,
    parameter int ADDRESSABLE_SIZE = 8,
    localparam int NUM_BE          = DATA_WIDTH / ADDRESSABLE_SIZE,
    localparam int PW              = $clog2(NUM_REQ)
) (
    input  logic                           clock,
    input  logic                           nReset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*NUM_BE-1:0]      req_be,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [ADDR_WIDTH-1:0]          ram_rdaddress,
    output logic                           ram_rden,
    output logic [ADDR_WIDTH-1:0]          ram_wraddress,
    output logic [DATA_WIDTH-1:0]          ram_data,
    output logic [NUM_BE-1:0]              ram_wren,
    input  logic [DATA_WIDTH-1:0]          ram_q
`ifdef RAM_SDP_ARB_STATS_EN
    ,
    output logic [15:0]                    stall_count
`endif
);

    logic [NUM_REQ-1:0] rd_c, wr_c, rd_gnt, wr_gnt;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_idx, wr_idx, rc, wc;
    logic [PW-1:0]      rd_tag_q, rd_tag_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_hit, wr_hit;

    // Candidates are masked while in reset so every grant and RAM strobe stays low.
    assign rd_c = nReset ? (req & ~req_wr) : '0;
    assign wr_c = nReset ? (req & req_wr) : '0;

    always_comb begin
        rd_hit = 1'b0;
        wr_hit = 1'b0;
        rd_idx = '0;
        wr_idx = '0;
        rc     = '0;
        wc     = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            rc = PW'((int'(rd_ptr_q) + j) % NUM_REQ);
            wc = PW'((int'(wr_ptr_q) + j) % NUM_REQ);
            if (!rd_hit && rd_c[rc]) begin
                rd_hit = 1'b1;
                rd_idx = rc;
            end
            if (!wr_hit && wr_c[wc]) begin
                wr_hit = 1'b1;
                wr_idx = wc;
            end
        end
    end

    assign rd_gnt = rd_hit ? NUM_REQ'(1) << rd_idx : '0;
    assign wr_gnt = wr_hit ? NUM_REQ'(1) << wr_idx : '0;
    assign gnt    = rd_gnt | wr_gnt;

    assign ram_rden      = rd_hit;
    assign ram_rdaddress = rd_hit ? req_addr[rd_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign ram_wraddress = wr_hit ? req_addr[wr_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign ram_data      = wr_hit ? req_wdata[wr_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign ram_wren      = wr_hit ? req_be[wr_idx*NUM_BE +: NUM_BE] : '0;

    always_comb begin
        rd_ptr_d   = rd_hit ? ((rd_idx == PW'(NUM_REQ - 1)) ? '0 : rd_idx + 1'b1) : rd_ptr_q;
        wr_ptr_d   = wr_hit ? ((wr_idx == PW'(NUM_REQ - 1)) ? '0 : wr_idx + 1'b1) : wr_ptr_q;
        rd_valid_d = rd_hit;
        rd_tag_d   = rd_hit ? rd_idx : rd_tag_q;
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_tag_q   <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_tag_q   <= rd_tag_d;
        end
    end

    // RAM q is already registered one cycle after rden, so it is returned as-is.
    assign rvalid = rd_valid_q ? NUM_REQ'(1) << rd_tag_q : '0;
    assign rdata  = ram_q;

`ifdef RAM_SDP_ARB_STATS_EN
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = (|(req & ~gnt) && stall_count_q != 16'hFFFF) ? stall_count_q + 16'd1 : stall_count_q;
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_ram_sdp_arbiter.sv
// tb_ram_sdp_arbiter: directed self-checking bench with a behavioural forwarding SDP RAM.
module tb_ram_sdp_arbiter;

    logic         clock = 1'b0;
    logic         nReset;
    logic [3:0]   req, req_wr, gnt, rvalid, ram_wren, req_be_unused;
    logic [31:0]  req_addr;
    logic [15:0]  req_be;
    logic [127:0] req_wdata;
    logic [31:0]  rdata, ram_data, ram_q, fwd;
    logic [7:0]   ram_rdaddress, ram_wraddress;
    logic         ram_rden;
    logic [31:0]  mem [256];
    int           checks = 0;
    int           errors = 0;
`ifdef RAM_SDP_ARB_STATS_EN
    logic [15:0]  stall_count;
`endif

    always #5 clock = ~clock;

    ram_sdp_arbiter dut (
        .clock(clock), .nReset(nReset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_be(req_be), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_rdaddress(ram_rdaddress), .ram_rden(ram_rden), .ram_wraddress(ram_wraddress),
        .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
`ifdef RAM_SDP_ARB_STATS_EN
        , .stall_count(stall_count)
`endif
    );

    // Reference RAM: registered read with same-cycle write forwarding per byte lane.
    always_comb begin
        fwd = mem[ram_rdaddress];
        for (int b = 0; b < 4; b++)
            if (ram_wren[b] && ram_wraddress == ram_rdaddress) fwd[b*8 +: 8] = ram_data[b*8 +: 8];
    end

    always @(posedge clock) begin
        if (ram_rden) ram_q <= fwd;
        for (int b = 0; b < 4; b++)
            if (ram_wren[b]) mem[ram_wraddress][b*8 +: 8] <= ram_data[b*8 +: 8];
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req = '0; req_wr = '0; req_addr = '0; req_be = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
        req[i] = 1'b1;
        req_wr[i] = wr;
        req_addr[i*8 +: 8] = a;
        req_be[i*4 +: 4] = be;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        idle();
        nReset = 1'b0;
        step();
        nReset = 1'b1;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        idle();
        req = 4'b1111;
        step();
        step();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL rst_rvalid: got %b want 0000", rvalid); end
        checks++; if (ram_rden !== 1'b0 || ram_wren !== 4'b0000) begin errors++; $display("FAIL rst_ram: rden %b wren %b want 0 0000", ram_rden, ram_wren); end
        nReset = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rst_first_gnt: got %b want 0001", gnt); end
        step();
        checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL rst_first_rvalid: got %b want 0001", rvalid); end
        idle();
        step();
    endtask

    task automatic test_write_read();
        set_req(0, 1'b1, 8'h10, 4'hF, 32'hAABBCCDD);
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wr_gnt: got %b want 0001", gnt); end
        checks++; if (ram_wren !== 4'hF || ram_wraddress !== 8'h10 || ram_data !== 32'hAABBCCDD)
            begin errors++; $display("FAIL wr_drive: wren %h addr %h data %h want f 10 aabbccdd", ram_wren, ram_wraddress, ram_data); end
        step();
        idle();
        set_req(2, 1'b0, 8'h10, 4'h0, 32'h0);
        #1;
        checks++; if (gnt !== 4'b0100 || ram_rden !== 1'b1 || ram_rdaddress !== 8'h10)
            begin errors++; $display("FAIL rd_gnt: gnt %b rden %b addr %h want 0100 1 10", gnt, ram_rden, ram_rdaddress); end
        step();
        idle();
        checks++; if (rvalid !== 4'b0100 || rdata !== 32'hAABBCCDD)
            begin errors++; $display("FAIL rd_data: rvalid %b rdata %h want 0100 aabbccdd", rvalid, rdata); end
        step();
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL rd_single_pulse: got %b want 0000", rvalid); end
    endtask

    task automatic test_partial_write();
        set_req(1, 1'b1, 8'h20, 4'hF, 32'h11223344);
        step();
        set_req(1, 1'b1, 8'h20, 4'b0010, 32'h0000FF00);
        step();
        set_req(1, 1'b1, 8'h20, 4'b0000, 32'hFFFFFFFF);
        #1;
        checks++; if (gnt !== 4'b0010 || ram_wren !== 4'b0000) begin errors++; $display("FAIL zero_be: gnt %b wren %b want 0010 0000", gnt, ram_wren); end
        step();
        idle();
        set_req(3, 1'b0, 8'h20, 4'h0, 32'h0);
        step();
        idle();
        checks++; if (rvalid !== 4'b1000 || rdata !== 32'h1122FF44)
            begin errors++; $display("FAIL partial_rd: rvalid %b rdata %h want 1000 1122ff44", rvalid, rdata); end
        step();
    endtask

    task automatic test_concurrent();
        set_req(1, 1'b1, 8'h30, 4'hF, 32'hCAFEBABE);
        set_req(3, 1'b0, 8'h30, 4'h0, 32'h0);
        #1;
        checks++; if (gnt !== 4'b1010) begin errors++; $display("FAIL conc_gnt: got %b want 1010", gnt); end
        step();
        idle();
        checks++; if (rvalid !== 4'b1000 || rdata !== 32'hCAFEBABE)
            begin errors++; $display("FAIL conc_rd: rvalid %b rdata %h want 1000 cafebabe", rvalid, rdata); end
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [3:0] exp_v;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h10, 4'h0, 32'h0);
        for (int c = 0; c < 8; c++) begin
            exp_g = 4'b0001 << (c % 4);
            exp_v = (c == 0) ? 4'b0000 : 4'b0001 << ((c - 1) % 4);
            #1;
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, gnt, exp_g); end
            checks++; if (rvalid !== exp_v) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b want %b", c, rvalid, exp_v); end
            if (c > 0) begin
                checks++; if (rdata !== 32'hAABBCCDD) begin errors++; $display("FAIL rr_rdata[%0d]: got %h want aabbccdd", c, rdata); end
            end
            step();
        end
        checks++; if (rvalid !== 4'b1000) begin errors++; $display("FAIL rr_last_rvalid: got %b want 1000", rvalid); end
        nReset = 1'b0;
        #1;
        checks++; if (rvalid !== 4'b0000 || gnt !== 4'b0000) begin errors++; $display("FAIL mid_reset: rvalid %b gnt %b want 0000 0000", rvalid, gnt); end
        step();
        nReset = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_reset_ptr: got %b want 0001", gnt); end
        idle();
        step();
    endtask

`ifdef RAM_SDP_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++; if (stall_count !== 16'h0000) begin errors++; $display("FAIL stats_reset: got %h want 0000", stall_count); end
        set_req(0, 1'b0, 8'h10, 4'h0, 32'h0);
        set_req(1, 1'b0, 8'h10, 4'h0, 32'h0);
        repeat (4) step();
        checks++; if (stall_count !== 16'd4) begin errors++; $display("FAIL stats_four: got %0d want 4", stall_count); end
        repeat (65530) step();
        checks++; if (stall_count !== 16'hFFFE) begin errors++; $display("FAIL stats_fffe: got %h want fffe", stall_count); end
        repeat (3) step();
        checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL stats_sat: got %h want ffff", stall_count); end
        idle();
        step();
    endtask
`endif

    initial begin
        nReset = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_partial_write();
        test_concurrent();
        test_round_robin();
`ifdef RAM_SDP_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
